// File: rtl/tlul_flat_sram_adapter.sv
// tlul_flat_sram_adapter
// Bridges a flattened TL-UL device port onto a single-port SRAM with a fixed
// one-cycle read latency. D-channel responses are buffered in a small
// in-order FIFO. A request is only accepted when a FIFO slot is guaranteed
// for its response, so the FIFO cannot overflow.
//
// Optional build macro: TLUL_FLAT_SRAM_ERRCHK_EN
//   Defined   - malformed requests (bad opcode, size > 2, misaligned, or out of
//               SRAM range) are acknowledged with denied = 1 and never reach
//               the SRAM.
//   Undefined - every accepted request is forwarded; denied is always 0.

`timescale 1ns/1ps

module tlul_flat_sram_adapter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int SZW    = 2,
    parameter int AIW    = 8,
    parameter int SramAw = 14,
    parameter int Depth  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              tl_a_valid,
    output logic              tl_a_ready,
    input  logic [2:0]        tl_a_bits_opcode,
    input  logic [2:0]        tl_a_bits_param,
    input  logic [SZW-1:0]    tl_a_bits_size,
    input  logic [AIW-1:0]    tl_a_bits_source,
    input  logic [AW-1:0]     tl_a_bits_address,
    input  logic [DW/8-1:0]   tl_a_bits_mask,
    input  logic [DW-1:0]     tl_a_bits_data,
    input  logic              tl_a_bits_corrupt,

    output logic              tl_d_valid,
    input  logic              tl_d_ready,
    output logic [2:0]        tl_d_bits_opcode,
    output logic [2:0]        tl_d_bits_param,
    output logic [SZW-1:0]    tl_d_bits_size,
    output logic [AIW-1:0]    tl_d_bits_source,
    output logic              tl_d_bits_sink,
    output logic [DW-1:0]     tl_d_bits_data,
    output logic              tl_d_bits_corrupt,
    output logic              tl_d_bits_denied,

    output logic              sram_req_o,
    output logic              sram_we_o,
    output logic [SramAw-1:0] sram_addr_o,
    output logic [DW/8-1:0]   sram_wmask_o,
    output logic [DW-1:0]     sram_wdata_o,
    input  logic [DW-1:0]     sram_rdata_i
);

    localparam int MW = DW / 8;
    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = PW + 1;

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;

    // ------------------------------------------------------------------
    // Credit accounting
    // ------------------------------------------------------------------
    logic [CW-1:0] count;
    logic          inflight;
    logic [CW:0]   credit_used;

    // A FIFO slot is reserved for every stored entry and for the access
    // whose data returns this cycle.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign tl_a_ready  = (credit_used < (CW + 1)'(Depth));

    logic accept;
    logic is_get;
    logic denied;
    logic forward;

    assign accept = tl_a_valid && tl_a_ready;
    assign is_get = (tl_a_bits_opcode == OpGet);

`ifdef TLUL_FLAT_SRAM_ERRCHK_EN
    logic bad_opcode;
    logic bad_size;
    logic misaligned;
    logic out_of_range;

    // Classify the A request; any violation turns it into a denied ack.
    always_comb begin
        bad_opcode   = !((tl_a_bits_opcode == OpPutFull) ||
                         (tl_a_bits_opcode == OpPutPartial) ||
                         (tl_a_bits_opcode == OpGet));
        bad_size     = (tl_a_bits_size > SZW'(2));
        misaligned   = 1'b0;
        if (tl_a_bits_size == SZW'(1)) begin
            misaligned = tl_a_bits_address[0];
        end else if (tl_a_bits_size == SZW'(2)) begin
            misaligned = |tl_a_bits_address[1:0];
        end
        out_of_range = |(tl_a_bits_address >> (SramAw + 2));
        denied       = bad_opcode || bad_size || misaligned || out_of_range;
    end
`else
    assign denied = 1'b0;
`endif

    assign forward = accept && !denied;

    // Drive the SRAM straight from the A fields in the accept cycle; every
    // output rests at zero otherwise.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wmask_o = '0;
        sram_wdata_o = '0;
        if (forward) begin
            sram_req_o  = 1'b1;
            sram_addr_o = tl_a_bits_address[SramAw+1:2];
            if (!is_get) begin
                // Anything that is not a Get writes; only PutPartial honours
                // the byte mask, a zero mask still strobes the SRAM.
                sram_we_o    = 1'b1;
                sram_wdata_o = tl_a_bits_data;
                sram_wmask_o = (tl_a_bits_opcode == OpPutPartial) ?
                               tl_a_bits_mask : {MW{1'b1}};
            end
        end
    end

    // ------------------------------------------------------------------
    // In-flight stage: response attributes wait here for the SRAM data
    // ------------------------------------------------------------------
    logic           if_get;
    logic [SZW-1:0] if_size;
    logic [AIW-1:0] if_source;
    logic           if_denied;

    // Track the access issued last cycle; reset drops it so no D beat is
    // produced for a pre-reset request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight  <= 1'b0;
            if_get    <= 1'b0;
            if_size   <= '0;
            if_source <= '0;
            if_denied <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                if_get    <= is_get;
                if_size   <= tl_a_bits_size;
                if_source <= tl_a_bits_source;
                if_denied <= denied;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic           push;
    logic           pop;
    logic [DW-1:0]  push_data;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    logic [DW-1:0]  fifo_data   [Depth];
    logic           fifo_get    [Depth];
    logic [SZW-1:0] fifo_size   [Depth];
    logic [AIW-1:0] fifo_source [Depth];
    logic           fifo_denied [Depth];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push      = inflight;
    assign pop       = tl_d_valid && tl_d_ready;
    // Denied Gets never touched the SRAM, so their data is forced to zero.
    assign push_data = (if_get && !if_denied) ? sram_rdata_i : '0;

    // Pointer and occupancy bookkeeping; push and pop together cancel out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: the head is only visible while count != 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr]   <= push_data;
            fifo_get[wr_ptr]    <= if_get;
            fifo_size[wr_ptr]   <= if_size;
            fifo_source[wr_ptr] <= if_source;
            fifo_denied[wr_ptr] <= if_denied;
        end
    end

    assign tl_d_valid = (count != '0);

    // Present the FIFO head; all fields read as zero while nothing is pending.
    always_comb begin
        tl_d_bits_opcode  = 3'd0;
        tl_d_bits_param   = 3'd0;
        tl_d_bits_size    = '0;
        tl_d_bits_source  = '0;
        tl_d_bits_sink    = 1'b0;
        tl_d_bits_data    = '0;
        tl_d_bits_corrupt = 1'b0;
        tl_d_bits_denied  = 1'b0;
        if (tl_d_valid) begin
            tl_d_bits_opcode = {2'b00, fifo_get[rd_ptr]};
            tl_d_bits_size   = fifo_size[rd_ptr];
            tl_d_bits_source = fifo_source[rd_ptr];
            tl_d_bits_data   = fifo_data[rd_ptr];
            tl_d_bits_denied = fifo_denied[rd_ptr];
        end
    end

    // Inputs the adapter deliberately ignores (param, corrupt, and the
    // address bits outside the word index when range checking is off).
    logic unused_inputs;
    assign unused_inputs = ^{tl_a_bits_param, tl_a_bits_corrupt,
                             tl_a_bits_address, tl_a_bits_mask};

endmodule

// File: tb/tb_tlul_flat_sram_adapter.sv
// Directed bench for tlul_flat_sram_adapter with a behavioural SRAM model.
// Build with +define+TLUL_FLAT_SRAM_ERRCHK_EN to also exercise denied responses.

`timescale 1ns/1ps

module tb_tlul_flat_sram_adapter;

    localparam logic [2:0] OP_PF  = 3'd0;
    localparam logic [2:0] OP_PP  = 3'd1;
    localparam logic [2:0] OP_GET = 3'd4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        tl_a_valid = 1'b0;
    logic        tl_a_ready;
    logic [2:0]  tl_a_bits_opcode = '0;
    logic [2:0]  tl_a_bits_param = '0;
    logic [1:0]  tl_a_bits_size = '0;
    logic [7:0]  tl_a_bits_source = '0;
    logic [31:0] tl_a_bits_address = '0;
    logic [3:0]  tl_a_bits_mask = '0;
    logic [31:0] tl_a_bits_data = '0;
    logic        tl_a_bits_corrupt = 1'b0;
    logic        tl_d_valid;
    logic        tl_d_ready = 1'b0;
    logic [2:0]  tl_d_bits_opcode;
    logic [2:0]  tl_d_bits_param;
    logic [1:0]  tl_d_bits_size;
    logic [7:0]  tl_d_bits_source;
    logic        tl_d_bits_sink;
    logic [31:0] tl_d_bits_data;
    logic        tl_d_bits_corrupt;
    logic        tl_d_bits_denied;
    logic        sram_req_o;
    logic        sram_we_o;
    logic [13:0] sram_addr_o;
    logic [3:0]  sram_wmask_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;

    int checks = 0;
    int errors = 0;

    tlul_flat_sram_adapter dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .tl_a_valid        (tl_a_valid),
        .tl_a_ready        (tl_a_ready),
        .tl_a_bits_opcode  (tl_a_bits_opcode),
        .tl_a_bits_param   (tl_a_bits_param),
        .tl_a_bits_size    (tl_a_bits_size),
        .tl_a_bits_source  (tl_a_bits_source),
        .tl_a_bits_address (tl_a_bits_address),
        .tl_a_bits_mask    (tl_a_bits_mask),
        .tl_a_bits_data    (tl_a_bits_data),
        .tl_a_bits_corrupt (tl_a_bits_corrupt),
        .tl_d_valid        (tl_d_valid),
        .tl_d_ready        (tl_d_ready),
        .tl_d_bits_opcode  (tl_d_bits_opcode),
        .tl_d_bits_param   (tl_d_bits_param),
        .tl_d_bits_size    (tl_d_bits_size),
        .tl_d_bits_source  (tl_d_bits_source),
        .tl_d_bits_sink    (tl_d_bits_sink),
        .tl_d_bits_data    (tl_d_bits_data),
        .tl_d_bits_corrupt (tl_d_bits_corrupt),
        .tl_d_bits_denied  (tl_d_bits_denied),
        .sram_req_o        (sram_req_o),
        .sram_we_o         (sram_we_o),
        .sram_addr_o       (sram_addr_o),
        .sram_wmask_o      (sram_wmask_o),
        .sram_wdata_o      (sram_wdata_o),
        .sram_rdata_i      (sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // SRAM model: 256 words; a word never written reads as A000_0000 | index.
    logic [31:0]  mem [256];
    logic [255:0] wr_seen;
    logic         mem_clr = 1'b1;
    logic [7:0]   ma;
    assign ma = sram_addr_o[7:0];

    always @(posedge clk_i) begin
        if (mem_clr) begin
            wr_seen <= '0;
        end else if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask_o[b]) mem[ma][8*b +: 8] <= sram_wdata_o[8*b +: 8];
                wr_seen[ma] <= 1'b1;
            end else begin
                sram_rdata_i <= wr_seen[ma] ? mem[ma] : (32'hA000_0000 | {24'd0, ma});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data, input logic [1:0] size, input logic [7:0] src);
        tl_a_valid        = 1'b1;
        tl_a_bits_opcode  = op;
        tl_a_bits_address = addr;
        tl_a_bits_mask    = mask;
        tl_a_bits_data    = data;
        tl_a_bits_size    = size;
        tl_a_bits_source  = src;
    endtask

    task automatic idle_a();
        tl_a_valid        = 1'b0;
        tl_a_bits_opcode  = '0;
        tl_a_bits_address = '0;
        tl_a_bits_mask    = '0;
        tl_a_bits_data    = '0;
        tl_a_bits_size    = '0;
        tl_a_bits_source  = '0;
    endtask

    // One isolated transaction with d_ready high: checks the SRAM strobe in
    // the accept cycle, nothing at N+1, the response at N+2, empty at N+3.
    task automatic single(input string nm, input logic [2:0] op, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                          input logic exp_req, input logic exp_we, input logic [3:0] exp_wmask,
                          input logic [2:0] exp_dop, input logic [31:0] exp_ddata,
                          input logic exp_denied);
        drive_a(op, addr, mask, data, 2'd2, src);
        #1;
        chk({nm, "_a_ready"}, tl_a_ready, 1);
        chk({nm, "_req"}, sram_req_o, exp_req);
        if (exp_req) begin
            chk({nm, "_we"}, sram_we_o, exp_we);
            chk({nm, "_addr"}, sram_addr_o, addr[15:2]);
            chk({nm, "_wmask"}, sram_wmask_o, exp_wmask);
            if (exp_we) chk({nm, "_wdata"}, sram_wdata_o, data);
        end
        tick();
        idle_a();
        #1;
        chk({nm, "_dvalid_n1"}, tl_d_valid, 0);
        tick();
        chk({nm, "_dvalid_n2"}, tl_d_valid, 1);
        chk({nm, "_dop"}, tl_d_bits_opcode, exp_dop);
        chk({nm, "_ddata"}, tl_d_bits_data, exp_ddata);
        chk({nm, "_dsrc"}, tl_d_bits_source, src);
        chk({nm, "_dsize"}, tl_d_bits_size, 2);
        chk({nm, "_ddenied"}, tl_d_bits_denied, exp_denied);
        chk({nm, "_dparam"}, tl_d_bits_param, 0);
        tick();
        chk({nm, "_dvalid_n3"}, tl_d_valid, 0);
    endtask

    initial begin
        int accepted;
        idle_a();
        rst_i   = 1'b1;
        mem_clr = 1'b1;
        repeat (3) tick();
        mem_clr = 1'b0;
        rst_i   = 1'b0;
        #1;
        chk("rst_a_ready", tl_a_ready, 1);
        chk("rst_d_valid", tl_d_valid, 0);
        chk("rst_d_opcode", tl_d_bits_opcode, 0);
        chk("rst_d_data", tl_d_bits_data, 0);
        chk("rst_d_source", tl_d_bits_source, 0);
        chk("rst_sram_req", sram_req_o, 0);
        chk("rst_sram_we", sram_we_o, 0);
        chk("rst_sram_addr", sram_addr_o, 0);
        chk("rst_sram_wmask", sram_wmask_o, 0);

        tl_d_ready = 1'b1;
        single("pf10", OP_PF, 32'h10, 4'h0, 32'hDEADBEEF, 8'h05, 1, 1, 4'hF, 3'd0, 32'h0, 0);
        single("get10", OP_GET, 32'h10, 4'h0, 32'h0, 8'h06, 1, 0, 4'h0, 3'd1, 32'hDEADBEEF, 0);
        single("pf20", OP_PF, 32'h20, 4'h0, 32'hFFFFFFFF, 8'h01, 1, 1, 4'hF, 3'd0, 32'h0, 0);
        single("pp20", OP_PP, 32'h20, 4'b0101, 32'h11223344, 8'h02, 1, 1, 4'b0101, 3'd0, 32'h0, 0);
        single("get20", OP_GET, 32'h20, 4'h0, 32'h0, 8'h03, 1, 0, 4'h0, 3'd1, 32'hFF22FF44, 0);

        // Eight back-to-back Gets: one response per cycle, in source order.
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive_a(OP_GET, 32'h100 + 32'(4 * k), 4'h0, 32'h0, 2'd2, 8'(k));
            else idle_a();
            #1;
            if (k < 8) chk("b2b_a_ready", tl_a_ready, 1);
            if (k >= 2) begin
                chk("b2b_d_valid", tl_d_valid, 1);
                chk("b2b_d_source", tl_d_bits_source, 32'(k - 2));
                chk("b2b_d_data", tl_d_bits_data, 32'hA0000040 + 32'(k - 2));
            end
            tick();
        end
        #1;
        chk("b2b_drained", tl_d_valid, 0);

        // Back-pressure: keep requesting with d_ready low; only Depth fit.
        tl_d_ready = 1'b0;
        accepted   = 0;
        for (int k = 0; k < 8; k++) begin
            drive_a(OP_GET, 32'h180 + 32'(4 * accepted), 4'h0, 32'h0, 2'd2, 8'(8'h10 + accepted));
            #1;
            if (tl_a_ready) accepted++;
            if (k >= 2) begin
                chk("bp_held_valid", tl_d_valid, 1);
                chk("bp_held_source", tl_d_bits_source, 8'h10);
                chk("bp_held_data", tl_d_bits_data, 32'hA0000060);
            end
            tick();
        end
        idle_a();
        #1;
        chk("bp_accepted", 32'(accepted), 4);
        chk("bp_a_ready_low", tl_a_ready, 0);
        tl_d_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_drain_valid", tl_d_valid, 1);
            chk("bp_drain_source", tl_d_bits_source, 32'(8'h10 + j));
            chk("bp_drain_data", tl_d_bits_data, 32'hA0000060 + 32'(j));
            tick();
        end
        chk("bp_drain_empty", tl_d_valid, 0);
        chk("bp_a_ready_back", tl_a_ready, 1);

`ifdef TLUL_FLAT_SRAM_ERRCHK_EN
        single("misalign", OP_GET, 32'h3, 4'h0, 32'h0, 8'h21, 0, 0, 4'h0, 3'd1, 32'h0, 1);
        single("badop", 3'd3, 32'h40, 4'hF, 32'h12345678, 8'h22, 0, 0, 4'h0, 3'd0, 32'h0, 1);
        single("range", OP_GET, 32'h0001_0000, 4'h0, 32'h0, 8'h23, 0, 0, 4'h0, 3'd1, 32'h0, 1);
        single("okafter", OP_GET, 32'h10, 4'h0, 32'h0, 8'h24, 1, 0, 4'h0, 3'd1, 32'hDEADBEEF, 0);
`endif

        // Reset the cycle after accepting a Get: its response must vanish.
        drive_a(OP_GET, 32'h200, 4'h0, 32'h0, 2'd2, 8'h33);
        #1;
        chk("mrst_a_ready", tl_a_ready, 1);
        tick();
        idle_a();
        rst_i = 1'b1;
        #1;
        chk("mrst_no_beat_n1", tl_d_valid, 0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("mrst_a_ready_after", tl_a_ready, 1);
        chk("mrst_d_valid_after", tl_d_valid, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mrst_no_beat_later", tl_d_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
